spi_mem_intf_p: RTL and testbench

Parametrised, request-driven SPI master that serialises single-word write and read commands to the SPI memory slave on one chip-select. It is the next-generation host-side interface of the SPI-MEM subsystem. Compared with the earlier interface it adds:
- configurable address and data widths and memory depth;
- an explicit start/busy handshake instead of free-running re-launch;
- wait timeouts on the slave handshakes;
- an error cause code and a read-data valid strobe.

---
 rtl/spi_mem_intf_p.sv | 163 ++++++++++++++++
 tb/tb_spi_mem_intf_p.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_intf_p.sv
// spi_mem_intf_p: request-driven SPI master for the SPI-MEM slave.
// Serialises one write {din, addr, 1} or read {addr, 0} frame LSB first,
// waits (bounded by TIMEOUT) for op_done / ready, and for reads shifts in
// DATA_W bits of miso LSB first. Requires DATA_W >= 3 and TIMEOUT >= 1.
module spi_mem_intf_p #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int MEM_DEPTH = 32,
   parameter int TIMEOUT   = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic              busy,
   output logic              cs,
   output logic              mosi,
   input  logic              miso,
   input  logic              ready,
   input  logic              op_done,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam int FRAME_W = 1 + ADDR_W + DATA_W;
   localparam int RD_LEN  = 1 + ADDR_W;
   localparam int CNT_W   = $clog2(2 + ADDR_W + DATA_W);
   localparam int WT_W    = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0]  WR_LAST = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0]  RD_LAST = CNT_W'(RD_LEN - 1);
   localparam logic [CNT_W-1:0]  RX_LAST = CNT_W'(DATA_W - 1);
   localparam logic [WT_W-1:0]   WT_LAST = WT_W'(TIMEOUT - 1);
   // One extra bit so MEM_DEPTH == 2**ADDR_W is representable.
   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(MEM_DEPTH);

   localparam logic [1:0] EC_NONE    = 2'b00;
   localparam logic [1:0] EC_ADDR    = 2'b01;
   localparam logic [1:0] EC_TIMEOUT = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_SEND, S_WAIT_DONE, S_WAIT_READY, S_RECV, S_DONE, S_ERROR
   } state_t;

   state_t             state;
   logic [FRAME_W-1:0] frame;   // shifts right; bit 0 is the next mosi bit
   logic               wr_q;
   logic [CNT_W-1:0]   cnt;
   logic [WT_W-1:0]    wcnt;
   logic [DATA_W-2:0]  rx;      // first DATA_W-1 received bits; last bit joins at load

   // Request FSM with registered SPI pins, status pulses and read data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         frame      <= '0;
         wr_q       <= 1'b0;
         cnt        <= '0;
         wcnt       <= '0;
         rx         <= '0;
         busy       <= 1'b0;
         cs         <= 1'b1;
         mosi       <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         err_code   <= EC_NONE;
      end else begin
         done       <= 1'b0;
         err        <= 1'b0;
         dout_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               cs   <= 1'b1;
               mosi <= 1'b0;
               if (start) begin
                  frame    <= {din, addr, wr};
                  wr_q     <= wr;
                  err_code <= EC_NONE;
                  busy     <= 1'b1;
                  state    <= S_CHECK;
               end
            end
            S_CHECK: begin
               if ({1'b0, frame[ADDR_W:1]} >= DEPTH_X) begin
                  err_code <= EC_ADDR;
                  err      <= 1'b1;
                  done     <= 1'b1;
                  state    <= S_ERROR;
               end else begin
                  // Bit 0 goes out together with cs falling.
                  cs    <= 1'b0;
                  mosi  <= frame[0];
                  frame <= frame >> 1;
                  cnt   <= '0;
                  state <= S_SEND;
               end
            end
            S_SEND: begin
               if (cnt == (wr_q ? WR_LAST : RD_LAST)) begin
                  cs    <= 1'b1;
                  mosi  <= 1'b0;
                  wcnt  <= '0;
                  state <= wr_q ? S_WAIT_DONE : S_WAIT_READY;
               end else begin
                  mosi  <= frame[0];
                  frame <= frame >> 1;
                  cnt   <= cnt + 1'b1;
               end
            end
            S_WAIT_DONE: begin
               if (op_done) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else if (wcnt == WT_LAST) begin
                  err_code <= EC_TIMEOUT;
                  err      <= 1'b1;
                  done     <= 1'b1;
                  state    <= S_ERROR;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            S_WAIT_READY: begin
               if (ready) begin
                  cnt   <= '0;
                  state <= S_RECV;
               end else if (wcnt == WT_LAST) begin
                  err_code <= EC_TIMEOUT;
                  err      <= 1'b1;
                  done     <= 1'b1;
                  state    <= S_ERROR;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            S_RECV: begin
               rx <= {miso, rx[DATA_W-2:1]};
               if (cnt == RX_LAST) begin
                  dout       <= {miso, rx};
                  dout_valid <= 1'b1;
                  done       <= 1'b1;
                  state      <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE, S_ERROR: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_mem_intf_p.sv
// Directed bench for spi_mem_intf_p: a default-width instance (TIMEOUT=4)
// and a wide instance (ADDR_W=10, DATA_W=16), a vector table plus
// hand-written reset-abort and held-start sequences.
module tb_spi_mem_intf_p;

   logic        clk = 1'b0;
   logic        rst;
   logic        start0, start1;
   logic        wr;
   logic [9:0]  addr;
   logic [15:0] din;
   logic        miso, ready, op_done;

   logic        busy0, cs0, mosi0, dv0, done0, err0;
   logic [1:0]  ec0;
   logic [7:0]  dout0;
   logic        busy1, cs1, mosi1, dv1, done1, err1;
   logic [1:0]  ec1;
   logic [15:0] dout1;

   int          sel;
   logic        cs_m, mosi_m, busy_m, done_m, err_m, dv_m;
   logic [1:0]  ec_m;
   logic [15:0] dout_m;

   int n_checks = 0;
   int n_fail   = 0;

   localparam int BOUND = 100;

   always #5 clk = ~clk;

   spi_mem_intf_p #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(32), .TIMEOUT(4)) u0 (
      .clk(clk), .rst(rst), .start(start0), .wr(wr), .addr(addr[7:0]), .din(din[7:0]),
      .busy(busy0), .cs(cs0), .mosi(mosi0), .miso(miso), .ready(ready), .op_done(op_done),
      .dout(dout0), .dout_valid(dv0), .done(done0), .err(err0), .err_code(ec0)
   );

   spi_mem_intf_p #(.ADDR_W(10), .DATA_W(16), .MEM_DEPTH(1024), .TIMEOUT(4)) u1 (
      .clk(clk), .rst(rst), .start(start1), .wr(wr), .addr(addr), .din(din),
      .busy(busy1), .cs(cs1), .mosi(mosi1), .miso(miso), .ready(ready), .op_done(op_done),
      .dout(dout1), .dout_valid(dv1), .done(done1), .err(err1), .err_code(ec1)
   );

   // Route the selected instance's outputs to one set of observation signals.
   always_comb begin
      if (sel != 0) begin
         cs_m = cs1; mosi_m = mosi1; busy_m = busy1; done_m = done1;
         err_m = err1; dv_m = dv1; ec_m = ec1; dout_m = dout1;
      end else begin
         cs_m = cs0; mosi_m = mosi0; busy_m = busy0; done_m = done0;
         err_m = err0; dv_m = dv0; ec_m = ec0; dout_m = {8'h00, dout0};
      end
   end

   typedef struct {
      int          sel;
      logic        wr;
      logic [9:0]  addr;
      logic [15:0] din;
      int          hs;         // wait cycles before handshake, -1 = never
      logic [15:0] rxw;        // word returned on miso for reads
      logic        noise;      // hold op_done/ready high while cs is low
      int          exp_len;
      logic [31:0] exp_frame;
      int          exp_done;   // negedge index (after accept edge) showing done
      logic        exp_err;
      logic [1:0]  exp_code;
      logic [15:0] exp_dout;
      logic        exp_dv;
   } rec_t;

   rec_t vec [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
      end
   endtask

   // Issue one request from the current negedge and follow it to done.
   task automatic run_vec(input rec_t v, input int idx);
      int          ph, wcnt, bit_i, len, done_cyc, dw;
      logic [31:0] cap;
      sel  = v.sel;
      dw   = (v.sel != 0) ? 16 : 8;
      wr   = v.wr; addr = v.addr; din = v.din;
      if (v.sel != 0) start1 = 1'b1; else start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      wr = ~v.wr; addr = ~v.addr; din = ~v.din;
      check($sformatf("v%0d busy_on", idx), busy_m, 1);
      check($sformatf("v%0d code_cleared", idx), ec_m, 0);
      cap = '0; len = 0; ph = 0; wcnt = 0; bit_i = 0; done_cyc = -1;
      for (int cyc = 0; cyc < BOUND && done_cyc < 0; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (!cs_m) begin
            if (len < 32) cap[len] = mosi_m;
            len++;
            ph = 1;
            op_done = v.noise; ready = v.noise;
         end else if (ph == 3) begin
            ready = 1'b0;
            if (bit_i < dw) miso = v.rxw[bit_i];
            bit_i++;
         end else if (ph >= 1) begin
            ph = 2;
            op_done = 1'b0; ready = 1'b0;
            if (v.hs >= 0 && wcnt == v.hs) begin
               if (v.wr) op_done = 1'b1;
               else begin ready = 1'b1; ph = 3; end
            end
            wcnt++;
         end
         if (done_m) begin
            done_cyc = cyc;
            check($sformatf("v%0d err", idx), err_m, v.exp_err);
            check($sformatf("v%0d dout_valid", idx), dv_m, v.exp_dv);
            check($sformatf("v%0d dout", idx), dout_m, v.exp_dout);
            check($sformatf("v%0d err_code", idx), ec_m, v.exp_code);
         end else begin
            check($sformatf("v%0d stray_pulse", idx), {err_m, dv_m}, 0);
         end
      end
      if (done_cyc < 0) begin
         n_checks++; n_fail++;
         $display("FAIL v%0d done_timeout: no done within %0d cycles", idx, BOUND);
      end
      check($sformatf("v%0d cs_low_len", idx), len, v.exp_len);
      check($sformatf("v%0d frame", idx), cap, v.exp_frame);
      check($sformatf("v%0d done_cycle", idx), done_cyc, v.exp_done);
      @(negedge clk);
      op_done = 1'b0; ready = 1'b0; miso = 1'b0;
      check($sformatf("v%0d done_one_cycle", idx), done_m, 0);
      check($sformatf("v%0d busy_off", idx), busy_m, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dcnt, falls;
      logic cs_prev;

      //        sel wr  addr     din       hs  rxw       nz   len frame          done err   code   dout      dv
      vec[0]  = '{0, 1'b1, 10'd5,    16'h00A5, 2,  16'h0000, 1'b1, 17, 32'h00014A0B, 21, 1'b0, 2'b00, 16'h0000, 1'b0};
      vec[1]  = '{0, 1'b0, 10'd5,    16'h0000, 1,  16'h003C, 1'b0, 9,  32'h0000000A, 20, 1'b0, 2'b00, 16'h003C, 1'b1};
      vec[2]  = '{0, 1'b1, 10'd32,   16'h0077, 0,  16'h0000, 1'b0, 0,  32'h00000000, 1,  1'b1, 2'b01, 16'h003C, 1'b0};
      vec[3]  = '{0, 1'b0, 10'd255,  16'h0000, 0,  16'h00FF, 1'b0, 0,  32'h00000000, 1,  1'b1, 2'b01, 16'h003C, 1'b0};
      vec[4]  = '{0, 1'b1, 10'd0,    16'h005A, -1, 16'h0000, 1'b0, 17, 32'h0000B401, 22, 1'b1, 2'b10, 16'h003C, 1'b0};
      vec[5]  = '{0, 1'b0, 10'd31,   16'h0000, -1, 16'h00AA, 1'b0, 9,  32'h0000003E, 14, 1'b1, 2'b10, 16'h003C, 1'b0};
      vec[6]  = '{0, 1'b0, 10'd31,   16'h0000, 0,  16'h00C3, 1'b1, 9,  32'h0000003E, 19, 1'b0, 2'b00, 16'h00C3, 1'b1};
      vec[7]  = '{0, 1'b1, 10'd31,   16'h00FF, 3,  16'h0000, 1'b0, 17, 32'h0001FE3F, 22, 1'b0, 2'b00, 16'h00C3, 1'b0};
      vec[8]  = '{1, 1'b1, 10'd1023, 16'hBEEF, 0,  16'h0000, 1'b1, 27, 32'h05F77FFF, 29, 1'b0, 2'b00, 16'h0000, 1'b0};
      vec[9]  = '{1, 1'b0, 10'd1023, 16'h0000, 1,  16'hBEEF, 1'b0, 11, 32'h000007FE, 30, 1'b0, 2'b00, 16'hBEEF, 1'b1};
      vec[10] = '{1, 1'b0, 10'd0,    16'h0000, 0,  16'h8001, 1'b0, 11, 32'h00000000, 29, 1'b0, 2'b00, 16'h8001, 1'b1};

      rst = 1'b0; start0 = 1'b0; start1 = 1'b0; wr = 1'b0; addr = '0; din = '0;
      miso = 1'b0; ready = 1'b0; op_done = 1'b0; sel = 0;
      repeat (2) @(negedge clk);
      check("rst cs0", cs0, 1);
      check("rst mosi0", mosi0, 0);
      check("rst busy0", busy0, 0);
      check("rst pulses0", {done0, err0, dv0}, 0);
      check("rst dout0", dout0, 0);
      check("rst err_code0", ec0, 0);
      check("rst cs1", cs1, 1);
      check("rst busy1", busy1, 0);
      check("rst dout1", dout1, 0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) run_vec(vec[i], i);

      // Reset while bit 6 of a write frame is on mosi.
      sel = 0;
      wr = 1'b1; addr = 10'd2; din = 16'h0033; start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (7) @(negedge clk);
      check("abort cs_low_before", cs_m, 0);
      check("abort bit6", mosi_m, 0);
      #2 rst = 1'b0;
      #1;
      check("abort cs_async", cs_m, 1);
      check("abort busy_async", busy_m, 0);
      check("abort mosi_async", mosi_m, 0);
      @(negedge clk);
      rst = 1'b1;
      check("abort dout_reset", dout_m, 0);
      dcnt = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (done_m || !cs_m) dcnt++;
      end
      check("abort no_done_no_cs", dcnt, 0);

      // start held high across several busy cycles.
      sel = 0;
      wr = 1'b1; addr = 10'd1; din = 16'h0011; start0 = 1'b1;
      dcnt = 0; falls = 0; cs_prev = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (k == 5) start0 = 1'b0;
         if (done_m) dcnt++;
         if (cs_prev && !cs_m) falls++;
         cs_prev = cs_m;
      end
      check("held_start done_count", dcnt, 1);
      check("held_start cs_frames", falls, 1);
      check("held_start timeout_code", ec_m, 2'b10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
